// File: rtl/btn_pkg.sv
// btn_pkg: colour codes, event-word bit layout and default debounce length shared by btn_event_queue.
package btn_pkg;
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int          NUM_BTNS                = 4;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      BLUE   = 2'd1,
      GREEN  = 2'd2,
      YELLOW = 2'd3
   } colour_e;

   localparam int EV_VALID_BIT = 31;
   localparam int EV_OVF_BIT   = 30;
   localparam int EV_TS_LSB    = 8;
   localparam int EV_TS_W      = 16;
   localparam int EV_COL_LSB   = 0;
   localparam int EV_COL_W     = 2;

   function automatic logic [31:0] pack_event(input logic valid, input logic ovf,
                                              input logic [EV_TS_W-1:0] ts, input colour_e col);
      logic [31:0] w;
      w                              = '0;
      w[EV_VALID_BIT]                = valid;
      w[EV_OVF_BIT]                  = ovf;
      w[EV_TS_LSB +: EV_TS_W]        = ts;
      w[EV_COL_LSB +: EV_COL_W]      = col;
      return w;
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser then a level that flips only after CYCLES consecutive differing samples.
module btn_debounce #(
   parameter int unsigned CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic level
);
   localparam int CW = $clog2(CYCLES + 1);

   logic [1:0]    sync_q, sync_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done;

   always_comb begin
      sync_d  = {sync_q[0], btn};
      done    = cnt_q == CW'(CYCLES - 1);
      level_d = level_q;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         level_d = done ? ~level_q : level_q;
         cnt_d   = done ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end

   assign level = level_q;
endmodule

// File: rtl/btn_event_queue.sv
// btn_event_queue: four debounced buttons -> priority arbiter -> press-event FIFO read by poll strobe.
// Define BTN_EVENT_TIMESTAMP_EN to capture a free-running 16-bit cycle stamp into each event.
module btn_event_queue
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned DEPTH           = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     red_button,
   input  logic                     blue_button,
   input  logic                     green_button,
   input  logic                     yellow_button,
   input  logic                     poll,
   output logic [31:0]              data_out,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [NUM_BTNS-1:0] raw, level, rise, grant;
   logic [NUM_BTNS-1:0] level_prev_q, level_prev_d, pend_q, pend_d;
   colour_e             gnt_col;
   logic                push_req, full, empty, pop, push, drop;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                ovf_q, ovf_d;
   colour_e             col_mem_q [DEPTH];
   logic [EV_TS_W-1:0]  head_ts;

   // Bit index equals colour code, so the arbiter's pick is directly the stored colour.
   assign raw = {yellow_button, green_button, blue_button, red_button};

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clock (clock),
         .reset (reset),
         .btn   (raw[i]),
         .level (level[i])
      );
   end

   always_comb begin
      level_prev_d = level;
      rise         = level & ~level_prev_q;
      push_req     = |pend_q;
      gnt_col      = pend_q[0] ? RED : pend_q[1] ? BLUE : pend_q[2] ? GREEN : YELLOW;
      grant        = {{(NUM_BTNS-1){1'b0}}, push_req} << gnt_col;
      pend_d       = (pend_q & ~grant) | rise;
      empty        = count_q == '0;
      full         = count_q == CW'(DEPTH);
      pop          = poll & ~empty;
      push         = push_req & (~full | pop);
      drop         = push_req & ~push;
      count_d      = count_q + CW'(push) - CW'(pop);
      wr_ptr_d     = wr_ptr_q + PW'(push);
      rd_ptr_d     = rd_ptr_q + PW'(pop);
      ovf_d        = (ovf_q & ~poll) | drop;
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         level_prev_q <= '0;
         pend_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         ovf_q        <= 1'b0;
         col_mem_q    <= '{default: RED};
      end else begin
         level_prev_q <= level_prev_d;
         pend_q       <= pend_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         ovf_q        <= ovf_d;
         if (push) col_mem_q[wr_ptr_q] <= gnt_col;
      end

`ifdef BTN_EVENT_TIMESTAMP_EN
   logic [EV_TS_W-1:0] ts_q, ts_d;
   logic [EV_TS_W-1:0] ts_mem_q [DEPTH];

   assign ts_d = ts_q + 1'b1;

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         ts_q     <= '0;
         ts_mem_q <= '{default: '0};
      end else begin
         ts_q <= ts_d;
         if (push) ts_mem_q[wr_ptr_q] <= ts_q;
      end

   assign head_ts = ts_mem_q[rd_ptr_q];
`else
   assign head_ts = '0;
`endif

   assign data_out = pack_event(~empty, ovf_q, empty ? '0 : head_ts, empty ? RED : col_mem_q[rd_ptr_q]);
   assign count    = count_q;
endmodule

// File: tb/tb_btn_event_queue.sv
// tb_btn_event_queue: directed + random stimulus against a windowed reference model, scoreboard-checked.
`timescale 1ns/1ps
module tb_btn_event_queue;
   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int MAXE  = 16384;
`ifdef BTN_EVENT_TIMESTAMP_EN
   localparam bit TS_ON = 1'b1;
`else
   localparam bit TS_ON = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  btn   = 4'b0;
   logic        poll  = 1'b0;
   logic [31:0] data_out;
   logic [2:0]  count;

   btn_event_queue #(.DEBOUNCE_CYCLES(N), .DEPTH(DEPTH)) dut (
      .clock         (clock),
      .reset         (reset),
      .red_button    (btn[0]),
      .blue_button   (btn[1]),
      .green_button  (btn[2]),
      .yellow_button (btn[3]),
      .poll          (poll),
      .data_out      (data_out),
      .count         (count)
   );

   always #5 clock = ~clock;

   // Reference model: a level flips once the last N synchronised samples all differ from it
   // and at least N edges have passed since its previous flip.
   typedef struct { logic [1:0] col; logic [15:0] ts; } ev_t;
   bit   raw [4][MAXE];
   int   ecount = 0;
   int   e0 = 1;
   bit   lvl [4];
   int   last_flip [4];
   bit   rose [4];
   bit   pend [4];
   bit   m_ovf;
   ev_t  fifo [$];

   function automatic void model_reset();
      e0 = ecount + 1;
      for (int b = 0; b < 4; b++) begin
         lvl[b] = 0; rose[b] = 0; pend[b] = 0; last_flip[b] = e0 - 1;
      end
      fifo.delete();
      m_ovf = 0;
   endfunction

   function automatic bit synced(int b, int k);
      return (k - 2 >= e0) ? raw[b][k-2] : 1'b0;
   endfunction

   function automatic void model_edge(int e);
      bit drop, all;
      int g;
      drop = 0;
      g = -1;
      for (int b = 0; b < 4; b++) raw[b][e] = btn[b];
      if (poll && fifo.size() > 0) void'(fifo.pop_front());
      for (int b = 3; b >= 0; b--) if (pend[b]) g = b;
      if (g >= 0) begin
         ev_t ev;
         ev.col = 2'(g);
         ev.ts  = 16'(e - e0);
         if (fifo.size() < DEPTH) fifo.push_back(ev);
         else drop = 1;
         pend[g] = 0;
      end
      m_ovf = (m_ovf && !poll) || drop;
      for (int b = 0; b < 4; b++) begin
         if (rose[b]) pend[b] = 1;
         rose[b] = 0;
         if (e - N >= last_flip[b]) begin
            all = 1;
            for (int j = 0; j < N; j++) if (synced(b, e - j) == lvl[b]) all = 0;
            if (all) begin
               lvl[b] = !lvl[b];
               last_flip[b] = e;
               rose[b] = lvl[b];
            end
         end
      end
   endfunction

   always @(posedge clock) begin
      ecount++;
      if (!reset) model_reset();
      else model_edge(ecount);
   end

   function automatic logic [31:0] exp_word();
      logic [31:0] w;
      w = '0;
      w[30] = m_ovf;
      if (fifo.size() > 0) begin
         w[31]   = 1'b1;
         w[1:0]  = fifo[0].col;
         w[23:8] = TS_ON ? fifo[0].ts : 16'h0;
      end
      return w;
   endfunction

   // Scoreboard: the driver queues what the outputs must read this cycle; the monitor compares.
   typedef struct { logic [31:0] d; logic [2:0] c; string name; } exp_t;
   exp_t sb [$];
   exp_t mon_x;
   int   errors = 0;
   int   checks = 0;

   function automatic void expect_now(string name);
      exp_t x;
      x.d = exp_word();
      x.c = 3'(fifo.size());
      x.name = name;
      sb.push_back(x);
   endfunction

   always @(negedge clock) begin
      #1;
      while (sb.size() > 0) begin
         mon_x = sb.pop_front();
         checks++;
         if (data_out !== mon_x.d) begin
            errors++;
            $display("FAIL %s data_out got %h want %h at %0t", mon_x.name, data_out, mon_x.d, $time);
         end
         checks++;
         if (count !== mon_x.c) begin
            errors++;
            $display("FAIL %s count got %0d want %0d at %0t", mon_x.name, count, mon_x.c, $time);
         end
      end
   end

   function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
      end
   endfunction

   task automatic step(input logic [3:0] b, input logic p = 1'b0, input string tag = "tick");
      @(negedge clock);
      btn  = b;
      poll = p;
      expect_now(p ? "poll" : tag);
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset(input logic [3:0] b);
      @(negedge clock);
      reset = 1'b0; btn = b; poll = 1'b0;
      model_reset();
      expect_now("reset");
      @(negedge clock);
      expect_now("reset_hold");
      @(negedge clock);
      reset = 1'b1;
      expect_now("release");
   endtask

   localparam logic [31:0] TS7 = TS_ON ? 32'h0000_0700 : 32'h0;

   initial begin
      logic [31:0] w1, w2;
      logic [3:0]  rb;

      // Green held from the first edge after reset: event visible exactly in cycle 8.
      do_reset(4'b0100);
      settle();
      chk("reset_data", data_out, 32'h0);
      chk("reset_count", 32'(count), 32'd0);
      for (int i = 1; i <= 7; i++) step(4'b0100);
      settle();
      chk("green_not_yet", 32'(data_out[31]), 32'd0);
      step(4'b0100);
      settle();
      chk("green_cycle8", data_out, 32'h8000_0002 | TS7);
      chk("green_count1", 32'(count), 32'd1);
      step(4'b0100, 1'b1);
      step(4'b0100);
      settle();
      chk("green_popped", data_out, 32'h0);
      chk("green_count0", 32'(count), 32'd0);
      step(4'b0100, 1'b1);
      for (int i = 0; i < 8; i++) step(4'b0000);

      // Red bouncing every 2 cycles never reaches a stable window.
      do_reset(4'b0000);
      for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 0 ? 4'b0001 : 4'b0000);
      for (int i = 0; i < 10; i++) step(4'b0000);
      settle();
      chk("bounce_count", 32'(count), 32'd0);

      // All four together come out in priority order.
      do_reset(4'b0000);
      for (int i = 0; i < 12; i++) step(4'b1111);
      settle();
      chk("all4_count", 32'(count), 32'd4);
      for (int k = 0; k < 4; k++) begin
         step(4'b1111, 1'b1);
         settle();
         chk("all4_colour", 32'(data_out[1:0]), 32'(k));
         step(4'b1111);
      end
      settle();
      chk("all4_empty", 32'(count), 32'd0);
      for (int i = 0; i < 8; i++) step(4'b0000);

      // Five presses into a depth-4 FIFO: the fifth is dropped and flags overflow.
      do_reset(4'b0000);
      for (int i = 0; i < 12; i++) step(4'b1111);
      for (int i = 0; i < 8; i++) step(4'b1110);
      for (int i = 0; i < 10; i++) step(4'b1111);
      settle();
      chk("ovf_count", 32'(count), 32'd4);
      chk("ovf_flag", 32'(data_out[30]), 32'd1);
      for (int k = 0; k < 4; k++) begin
         step(4'b1111, 1'b1);
         settle();
         chk("ovf_colour", 32'(data_out[1:0]), 32'(k));
         step(4'b1111);
         settle();
         chk("ovf_cleared", 32'(data_out[30]), 32'd0);
      end
      for (int i = 0; i < 8; i++) step(4'b0000);

      // Reset in the middle of blue's debounce window restarts the whole window.
      do_reset(4'b0000);
      for (int i = 0; i < 4; i++) step(4'b0010);
      do_reset(4'b0010);
      for (int i = 1; i <= 7; i++) step(4'b0010);
      settle();
      chk("blue_not_yet", 32'(data_out[31]), 32'd0);
      step(4'b0010);
      settle();
      chk("blue_cycle8", data_out, 32'h8000_0001 | TS7);
      step(4'b0010, 1'b1);
      for (int i = 0; i < 8; i++) step(4'b0000);

      // Two red presses 100 cycles apart.
      do_reset(4'b0000);
      for (int i = 0; i < 100; i++) step(i < 10 ? 4'b0001 : 4'b0000);
      for (int i = 0; i < 20; i++) step(i < 10 ? 4'b0001 : 4'b0000);
      step(4'b0000, 1'b1);
      settle();
      w1 = data_out;
      step(4'b0000);
      step(4'b0000, 1'b1);
      settle();
      w2 = data_out;
      chk("ts_diff", 32'(w2[23:8] - w1[23:8]), TS_ON ? 32'd100 : 32'd0);
      chk("ts_second_valid", 32'(w2[31]), 32'd1);
      step(4'b0000);

      // Random buttons with bounce, random polls, and one reset in the middle.
      do_reset(4'b0000);
      rb = 4'b0000;
      for (int i = 0; i < 2500; i++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) rb[b] = ~rb[b];
         if (i == 1200) do_reset(rb);
         else step(rb, $urandom_range(0, 4) == 0);
      end
      for (int i = 0; i < 40; i++) step(4'b0000, 1'b1);

      @(negedge clock);
      #3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
